// File: rtl/elevator_scan_ctrl.sv
// Single-car SCAN elevator controller: pending-floor bitmap, timed travel and door dwell.
// Optional emergency stop input (freezes timers and motion) enabled by defining ESTOP_EN.
module elevator_scan_ctrl #(
  parameter int NUM_FLOORS    = 16,
  parameter int FLOOR_W       = $clog2(NUM_FLOORS),
  parameter int TRAVEL_CYCLES = 2,
  parameter int DOOR_CYCLES   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef ESTOP_EN
  input  logic                  estop,
`endif
  input  logic                  req_valid,
  input  logic [FLOOR_W-1:0]    req_floor,
  output logic [FLOOR_W-1:0]    cur_floor,
  output logic                  up,
  output logic                  down,
  output logic                  door_open,
  output logic                  stopped,
  output logic                  arrive,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int TW = $clog2(TRAVEL_CYCLES + 1);
  localparam int DW = $clog2(DOOR_CYCLES + 1);
  localparam logic [TW-1:0]      TRAVEL_LOAD = TW'(TRAVEL_CYCLES);
  localparam logic [DW-1:0]      DOOR_LOAD   = DW'(DOOR_CYCLES);
  localparam logic [FLOOR_W:0]   FLOOR_LIMIT = (FLOOR_W + 1)'(NUM_FLOORS);

  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

  state_t                state_reg, state_next;
  logic                  dir_up_reg, dir_up_next;
  logic [FLOOR_W-1:0]    floor_reg, floor_next;
  logic [TW-1:0]         travel_reg, travel_next;
  logic [DW-1:0]         door_reg, door_next;
  logic                  arrive_reg, arrive_next;
  logic [NUM_FLOORS-1:0] pending_reg, pending_next;

  logic                  frozen;
  logic                  req_hit, req_here;
  logic [NUM_FLOORS-1:0] set_vec, clr_vec;
  logic [NUM_FLOORS-1:0] above, below;
  logic                  any_ahead, any_behind;
  logic [FLOOR_W-1:0]    step_floor;

`ifdef ESTOP_EN
  assign frozen = estop;
`else
  assign frozen = 1'b0;
`endif

  // Pending floors strictly above / below the car, used for SCAN direction choice.
  generate
    for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_side
      assign above[gi] = pending_reg[gi] && (FLOOR_W'(gi) > floor_reg);
      assign below[gi] = pending_reg[gi] && (FLOOR_W'(gi) < floor_reg);
    end
  endgenerate

  assign any_ahead  = dir_up_reg ? (|above) : (|below);
  assign any_behind = dir_up_reg ? (|below) : (|above);
  assign step_floor = dir_up_reg ? floor_reg + FLOOR_W'(1) : floor_reg - FLOOR_W'(1);
  assign req_hit    = req_valid && ({1'b0, req_floor} < FLOOR_LIMIT);
  assign req_here   = req_hit && (req_floor == floor_reg);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      dir_up_reg  <= 1'b1;
      floor_reg   <= '0;
      travel_reg  <= '0;
      door_reg    <= '0;
      arrive_reg  <= 1'b0;
      pending_reg <= '0;
    end else begin
      state_reg   <= state_next;
      dir_up_reg  <= dir_up_next;
      floor_reg   <= floor_next;
      travel_reg  <= travel_next;
      door_reg    <= door_next;
      arrive_reg  <= arrive_next;
      pending_reg <= pending_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    dir_up_next = dir_up_reg;
    floor_next  = floor_reg;
    travel_next = travel_reg;
    door_next   = door_reg;
    arrive_next = 1'b0;
    set_vec     = '0;
    clr_vec     = '0;

    // A call for the floor the car is parked at is answered by the door, not latched.
    if (req_hit && !(req_here && state_reg != MOVE))
      set_vec = NUM_FLOORS'(1) << req_floor;

    if (!frozen) begin
      case (state_reg)
        IDLE: begin
          if (req_here) begin
            state_next = DOOR;
            door_next  = DOOR_LOAD;
          end else if (|pending_reg) begin
            if (!any_ahead)
              dir_up_next = ~dir_up_reg;
            state_next  = MOVE;
            travel_next = TRAVEL_LOAD;
          end
        end
        MOVE: begin
          if (travel_reg == TW'(1)) begin
            floor_next  = step_floor;
            travel_next = TRAVEL_LOAD;
            if (pending_reg[step_floor]) begin
              clr_vec     = NUM_FLOORS'(1) << step_floor;
              arrive_next = 1'b1;
              state_next  = DOOR;
              door_next   = DOOR_LOAD;
            end
          end else begin
            travel_next = travel_reg - TW'(1);
          end
        end
        DOOR: begin
          if (req_here) begin
            door_next = DOOR_LOAD;
          end else if (door_reg == DW'(1)) begin
            door_next = '0;
            if (any_ahead) begin
              state_next  = MOVE;
              travel_next = TRAVEL_LOAD;
            end else if (any_behind) begin
              dir_up_next = ~dir_up_reg;
              state_next  = MOVE;
              travel_next = TRAVEL_LOAD;
            end else begin
              state_next = IDLE;
            end
          end else begin
            door_next = door_reg - DW'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end

    // Clear beats a same-cycle set: the car is standing at that floor.
    pending_next = (pending_reg | set_vec) & ~clr_vec;

    door_open = (state_reg != MOVE);
    stopped   = (state_reg != MOVE) || frozen;
    up        = (state_reg == MOVE) && dir_up_reg && !frozen;
    down      = (state_reg == MOVE) && !dir_up_reg && !frozen;
  end

  assign cur_floor = floor_reg;
  assign arrive    = arrive_reg;
  assign pending   = pending_reg;

endmodule
